// File: rtl/cpu_link_pkg.sv
// cpu_link_pkg: link word width and handshake FSM encodings shared by both ends of the CPU link
package cpu_link_pkg;
  localparam int LINK_DATA_W = 4;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACK_HI = 1'b1
  } link_state_t;
endpackage

// File: rtl/link_fifo.sv
// link_fifo: first-word fall-through FIFO; ports clk/rst, i_wr_en/i_wr_data push, i_rd_en pop, o_head/o_count/o_full/o_empty status
module link_fifo #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_rd_en,
  output logic [DATA_W-1:0]          o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_wr, w_rd;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == CW'(DEPTH);
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;
  // head is masked while empty because the storage is never cleared
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= w_rd ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count  <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end
endmodule

// File: rtl/periph_receiver.sv
// periph_receiver: 4-phase send/ack link receiver buffering nibbles into a FIFO with a valid/ready consumer side
//   rx_clk/rx_rst          clock, async active-high reset
//   rx_send/rx_dados       CPU request and data; rx_ack registered acknowledge back to CPU
//   rx_data/rx_valid       FIFO head and non-empty flag; rx_ready pops the head
//   rx_count/rx_full       occupancy and full flag
module periph_receiver
  import cpu_link_pkg::*;
#(
  parameter int DATA_W      = LINK_DATA_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       rx_clk,
  input  logic                       rx_rst,
  input  logic                       rx_send,
  input  logic [DATA_W-1:0]          rx_dados,
  output logic                       rx_ack,
  output logic [DATA_W-1:0]          rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic                       rx_full
);
  logic [SYNC_STAGES-1:0] r_sync;
  link_state_t            r_state, w_state_nxt;
  logic                   w_send_s, w_wr, w_empty;
  assign w_send_s = r_sync[SYNC_STAGES-1];
  assign rx_ack   = r_state == ST_ACK_HI;
  assign rx_valid = !w_empty;
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      r_sync  <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_sync  <= SYNC_STAGES'({r_sync, rx_send});
      r_state <= w_state_nxt;
    end
  end
  // a full FIFO withholds the capture, which is what stalls ack towards the CPU
  always_comb begin
    w_wr        = r_state == ST_IDLE && w_send_s && !rx_full;
    w_state_nxt = w_wr ? ST_ACK_HI : (r_state == ST_ACK_HI && !w_send_s) ? ST_IDLE : r_state;
  end
  link_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (rx_clk),
    .rst      (rx_rst),
    .i_wr_en  (w_wr),
    .i_wr_data(rx_dados),
    .i_rd_en  (rx_ready),
    .o_head   (rx_data),
    .o_count  (rx_count),
    .o_full   (rx_full),
    .o_empty  (w_empty)
  );
endmodule

// File: tb/tb_periph_receiver.sv
// tb_periph_receiver: directed self-checking bench for periph_receiver
module tb_periph_receiver;
  logic       clk = 1'b0, rst = 1'b1, send = 1'b0, ready = 1'b0;
  logic [3:0] dados = '0, data;
  logic       ack, valid, full;
  logic [2:0] count;
  int         n_cmp = 0, n_bad = 0, max_cnt = 0;
  bit         mon = 1'b0;
  logic [3:0] seen[$];
  periph_receiver dut (
    .rx_clk  (clk),
    .rx_rst  (rst),
    .rx_send (send),
    .rx_dados(dados),
    .rx_ack  (ack),
    .rx_data (data),
    .rx_valid(valid),
    .rx_ready(ready),
    .rx_count(count),
    .rx_full (full)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mon) begin
      if (valid && ready) seen.push_back(data);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (ack !== v && n < 20) begin
      tick();
      n++;
    end
    chk(tag, ack, v);
  endtask
  task automatic xfer(input logic [3:0] d);
    send = 1'b1;
    dados = d;
    wait_ack(1'b1, "xfer_ack_hi");
    send = 1'b0;
    wait_ack(1'b0, "xfer_ack_lo");
  endtask
  initial begin
    #10 rst = 1'b0;
    chk("rst_ack", ack, 0);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_data", data, 0);
    // 1: capture latency and ack release latency
    send = 1'b1;
    dados = 4'hA;
    tick(2);
    chk("t1_ack_edge2", ack, 0);
    tick();
    chk("t1_ack_edge3", ack, 1);
    chk("t1_valid", valid, 1);
    chk("t1_data", data, 4'hA);
    chk("t1_count", count, 1);
    send = 1'b0;
    tick(2);
    chk("t1_ack_hold", ack, 1);
    tick();
    chk("t1_ack_drop", ack, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t1_popped", count, 0);
    // 2: fill, backpressure, release by a single pop
    for (int i = 1; i <= 4; i++) xfer(4'(i));
    chk("t2_full", full, 1);
    chk("t2_count4", count, 4);
    send = 1'b1;
    dados = 4'h5;
    tick(6);
    chk("t2_bp_ack", ack, 0);
    chk("t2_bp_count", count, 4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t2_pop_ack", ack, 0);
    chk("t2_pop_count", count, 3);
    tick();
    chk("t2_late_ack", ack, 1);
    chk("t2_late_count", count, 4);
    send = 1'b0;
    wait_ack(1'b0, "t2_ack_lo");
    for (int i = 2; i <= 5; i++) begin
      chk("t2_order", data, i);
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    chk("t2_empty", valid, 0);
    // 3: streaming with continuous ready, pointers wrap twice
    ready = 1'b1;
    mon = 1'b1;
    for (int i = 0; i < 8; i++) xfer(4'(i));
    tick(2);
    mon = 1'b0;
    chk("t3_n_seen", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("t3_seq", seen[i], i);
    chk("t3_max_count", max_cnt, 1);
    ready = 1'b0;
    // 4: data changing after capture is ignored
    send = 1'b1;
    dados = 4'h6;
    wait_ack(1'b1, "t4_ack_hi");
    dados = 4'h9;
    tick(3);
    send = 1'b0;
    wait_ack(1'b0, "t4_ack_lo");
    chk("t4_count", count, 1);
    chk("t4_data", data, 4'h6);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    // 5: reset in the middle of a handshake, word is re-captured
    xfer(4'h1);
    send = 1'b1;
    dados = 4'hC;
    wait_ack(1'b1, "t5_ack_hi");
    chk("t5_count2", count, 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_count", count, 0);
    tick();
    rst = 1'b0;
    wait_ack(1'b1, "t5_recap_ack");
    chk("t5_recap_count", count, 1);
    chk("t5_recap_data", data, 4'hC);
    send = 1'b0;
    wait_ack(1'b0, "t5_ack_lo");
    ready = 1'b1;
    tick();
    // 6: pop while empty is ignored
    tick(3);
    chk("t6_count", count, 0);
    chk("t6_valid", valid, 0);
    ready = 1'b0;
    xfer(4'h7);
    chk("t6_after_count", count, 1);
    chk("t6_after_data", data, 4'h7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
